// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: widths and FUNCT codes shared by the HI/LO unit
package mult_div_unit_pkg;
  localparam int DATA_W = 32;
  localparam int FUNCT_W = 6;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: EX-stage request and HI/LO result bundle
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;
  logic               start;
  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  operand_1;
  logic [DATA_W-1:0]  operand_2;
  logic               flush;
  logic               stall_req;
  logic               done;
  logic [DATA_W-1:0]  hi;
  logic [DATA_W-1:0]  lo;
  logic [DATA_W-1:0]  result;
  modport master (output start, funct, operand_1, operand_2, flush, input stall_req, done, hi, lo, result);
  modport slave (input start, funct, operand_1, operand_2, flush, output stall_req, done, hi, lo, result);
endinterface

// File: rtl/mult_div_unit_div_restoring.sv
// div_restoring: 32-step restoring unsigned divider, one quotient bit per cycle
module div_restoring
  import mult_div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  logic [4:0]        cnt;
  logic              run;
  logic [DATA_W-1:0] quo, rem, dsr;
  logic [DATA_W:0]   partial, diff;
  logic              ge;
  always_comb begin
    partial   = {rem, quo[DATA_W-1]};
    diff      = partial - {1'b0, dsr};
    ge        = partial >= {1'b0, dsr};
    busy      = run;
    done      = run && cnt == 5'd31;
    quotient  = quo;
    remainder = rem;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start && !run) begin
      run <= 1'b1;
      cnt <= '0;
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (run) begin
      rem <= ge ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
      quo <= {quo[DATA_W-2:0], ge};
      cnt <= cnt + 5'd1;
      run <= cnt != 5'd31;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO owner running iterative MULT/DIV and single-cycle MTxx/MFxx
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t              state, nxt;
  logic [4:0]          cnt;
  logic [2*DATA_W-1:0] prod, m_fix;
  logic [DATA_W-1:0]   mcand, abs_a, abs_b, q, r, q_fix, r_fix, hi, lo;
  logic [DATA_W:0]     sum;
  logic                nq, nr, dz, op_div, is_mul, is_div, sgn, sa, sb;
  logic                accept, commit, dv_busy, dv_done;
  always_comb begin
    is_mul      = bus.funct == FUNCT_MULT || bus.funct == FUNCT_MULTU;
    is_div      = bus.funct == FUNCT_DIV || bus.funct == FUNCT_DIVU;
    sgn         = bus.funct == FUNCT_MULT || bus.funct == FUNCT_DIV;
    sa          = sgn && bus.operand_1[DATA_W-1];
    sb          = sgn && bus.operand_2[DATA_W-1];
    abs_a       = sa ? -bus.operand_1 : bus.operand_1;
    abs_b       = sb ? -bus.operand_2 : bus.operand_2;
    accept      = state == IDLE && bus.start && !bus.flush;
    commit      = state == DONE && !bus.flush;
    sum         = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, mcand & {DATA_W{prod[0]}}};
    m_fix       = nq ? -prod : prod;
    q_fix       = dz ? '1 : nq ? -q : q;
    r_fix       = nr ? -r : r;
    nxt         = bus.flush ? IDLE :
                  state == IDLE ? (accept && is_mul ? MUL : accept && is_div ? DIV : IDLE) :
                  state == MUL ? (cnt == 5'd31 ? DONE : MUL) :
                  state == DIV ? (dv_done ? DONE : DIV) : IDLE;
    bus.stall_req = (accept && (is_mul || is_div)) || state == MUL || (state == DIV && dv_busy);
    bus.done    = commit;
    bus.hi      = hi;
    bus.lo      = lo;
    bus.result  = bus.funct == FUNCT_MFHI ? hi : bus.funct == FUNCT_MFLO ? lo : '0;
  end
  div_restoring u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div),
    .abort     (bus.flush),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .busy      (dv_busy),
    .done      (dv_done),
    .quotient  (q),
    .remainder (r)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      nq     <= 1'b0;
      nr     <= 1'b0;
      dz     <= 1'b0;
      op_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= nxt;
      if (accept && is_mul) begin
        cnt   <= '0;
        prod  <= {{DATA_W{1'b0}}, abs_b};
        mcand <= abs_a;
      end else if (state == MUL) begin
        cnt  <= cnt + 5'd1;
        prod <= {sum, prod[DATA_W-1:1]};
      end
      if (accept && (is_mul || is_div)) begin
        nq     <= sa ^ sb;
        nr     <= sa;
        dz     <= bus.operand_2 == '0;
        op_div <= is_div;
      end
      if (commit) {hi, lo} <= op_div ? {r_fix, q_fix} : m_fix;
      else if (accept && bus.funct == FUNCT_MTHI) hi <= bus.operand_1;
      else if (accept && bus.funct == FUNCT_MTLO) lo <= bus.operand_1;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table plus flush/reset corner sequences
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, h, l;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prev_stall = 1'b0;
  int   passed = 0;
  int   total = 0;
  logic [31:0] cur_hi, cur_lo;
  vec_t v [10];
  mult_div_unit_if bus();
  mult_div_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst && prev_stall && bus.stall_req)
      assert (!bus.start) else $error("FAIL start_while_busy");
    prev_stall <= bus.stall_req;
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  task automatic accept_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = f;
    bus.operand_1 = a;
    bus.operand_2 = b;
    #1;
  endtask
  task automatic run_vec(input int i);
    int lat, n_stall;
    logic got;
    accept_op(v[i].f, v[i].a, v[i].b);
    n_stall = int'(bus.stall_req);
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!got && lat < 40) begin
      lat++;
      #1;
      n_stall += int'(bus.stall_req);
      if (bus.done) got = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("v%0d_latency", i), lat, 33);
    chk($sformatf("v%0d_stall_cycles", i), n_stall, 33);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
    chk($sformatf("v%0d_hi", i), bus.hi, v[i].h);
    chk($sformatf("v%0d_lo", i), bus.lo, v[i].l);
    bus.funct = FUNCT_MFHI;
    #1 chk($sformatf("v%0d_mfhi", i), bus.result, v[i].h);
    bus.funct = FUNCT_MFLO;
    #1 chk($sformatf("v%0d_mflo", i), bus.result, v[i].l);
    bus.funct = '0;
    cur_hi = v[i].h;
    cur_lo = v[i].l;
  endtask
  initial begin
    int dpulse;
    v[0] = '{FUNCT_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    v[1] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[3] = '{FUNCT_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    v[4] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[5] = '{FUNCT_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    v[6] = '{FUNCT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    v[7] = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    v[8] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    v[9] = '{FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    bus.start = 1'b0;
    bus.funct = '0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    chk("reset_stall", bus.stall_req, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    accept_op(FUNCT_MTHI, 32'h1234, 32'h0);
    chk("mthi_stall", bus.stall_req, 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.funct = FUNCT_MFLO;
    #1 chk("mflo_after_mthi", bus.result, 0);
    bus.funct = FUNCT_MFHI;
    #1 chk("mfhi_after_mthi", bus.result, 32'h1234);
    chk("mthi_stall_after", bus.stall_req, 0);
    accept_op(FUNCT_MTLO, 32'h5555, 32'h0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1 chk("flush_blocks_mtlo", bus.lo, 0);
    for (int i = 0; i < 10; i++) run_vec(i);
    accept_op(FUNCT_DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_div_stall", bus.stall_req, 0);
    dpulse = 0;
    repeat (40) begin
      @(negedge clk);
      #1 dpulse += int'(bus.done);
    end
    chk("flush_div_no_done", dpulse, 0);
    chk("flush_div_hi", bus.hi, cur_hi);
    chk("flush_div_lo", bus.lo, cur_lo);
    accept_op(FUNCT_MULT, 32'd5, 32'd6);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (31) @(negedge clk);
    bus.flush = 1'b1;
    #1 chk("flush_done_suppressed", bus.done, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_done_hi", bus.hi, cur_hi);
    chk("flush_done_lo", bus.lo, cur_lo);
    chk("flush_done_stall", bus.stall_req, 0);
    accept_op(FUNCT_MULT, 32'd5, 32'd6);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_mul_hi", bus.hi, 0);
    chk("rst_mid_mul_lo", bus.lo, 0);
    chk("rst_mid_mul_stall", bus.stall_req, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
